irq_bank_ctrl: RTL
==================

Name: irq_bank_ctrl

Overview:
- Interrupt/trap sequencer directly upstream of the banked register file.
- Collects 8 external interrupt lines plus a software trap, and prioritises them against the control register read back from the register file.
- At instruction boundaries it switches the register file into the supervisor bank and writes the cause code into supervisor R1.
- Drives the register file `bank` and `sr1_wr` inputs; `take` tells fetch to jump to the vector held in supervisor R7.

Parameters:
- NIRQ, 8, number of external interrupt lines (fixed at 8; cause encoding relies on it).
- CAUSE_BASE, 16'h0008, cause code for line i is CAUSE_BASE | i.
- TRAP_CAUSE, 16'h0010, cause code for the software trap.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- irq  in  8  asynchronous level interrupt lines; rising edge requests service.
- trap  in  1  synchronous software-trap strobe, one cycle.
- cr_rd  in  16  control register from the register file. Bit 0 = global interrupt enable (IE). Bits 15:8 = per-line enable mask, bit 8+i for line i.
- instr_done  in  1  one-cycle strobe at each instruction boundary.
- reti  in  1  one-cycle return-from-interrupt strobe.
- bank  out  1  register-bank select to the register file: 0 = user, 1 = supervisor.
- sr1_wr  out  16  cause value for supervisor R1; 16'h0000 means no write.
- take  out  1  one-cycle pulse to fetch: load the vector.
- pending  out  8  latched, not-yet-serviced interrupt lines (debug readback).
- busy  out  1  high while in ENTER, SERVICE or EXIT.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; bank = 0; sr1_wr = 0; take = 0; pending = 0; trap_pend = 0; synchroniser flops = 0.
  - Reset asserted mid-service returns to IDLE / user bank at once; no cause write occurs.
- Synchroniser and edge detect:
  - Each irq bit passes through two flops (s1, s2), then a history flop s3.
  - Edge = s2 & ~s3. A raw rise sampled at posedge N sets pending[i] at posedge N+2 (visible after N+2).
  - Level-held lines do not re-request; a fresh rising edge is required.
- Trap: trap = 1 sets trap_pend at the next posedge.
- Eligibility, evaluated combinationally in IDLE:
  - Trap is eligible whenever trap_pend = 1, regardless of IE.
  - Line i is eligible when pending[i] & cr_rd[0] & cr_rd[8+i].
- Priority: trap first, then the lowest line index.
- State machine (posedge clk):
  - IDLE: bank = 0. If instr_done = 1 and any source is eligible, go to ENTER and latch the winning cause; otherwise stay.
  - ENTER (exactly 1 cycle):
    - bank = 1; take = 1.
    - sr1_wr = latched cause (TRAP_CAUSE, or CAUSE_BASE | idx).
    - Clear the winner's pending bit (or trap_pend) at the end of the cycle.
    - Go to SERVICE.
  - SERVICE: bank = 1; sr1_wr = 0. No nesting: instr_done and new requests are ignored (they still latch into pending). reti = 1 goes to EXIT.
  - EXIT (exactly 1 cycle): bank = 1; go to IDLE. bank = 0 from the next cycle.
    - A request eligible in IDLE on the following instr_done is taken normally; there is no extra bubble.
- Outputs: sr1_wr and take are registered and nonzero only in ENTER. busy = (state != IDLE).
- Boundary conditions:
  - If a new edge on line i and the clear of pending[i] land on the same posedge, the set wins and the bit stays 1.
  - trap strobe during ENTER on which trap_pend is cleared: set wins.
  - reti in IDLE or ENTER: ignored.
  - instr_done without an eligible source: no effect.
  - Masked or IE = 0 pending bits stay latched; they are taken once enabled, at the next instr_done.
  - If several lines become eligible together, the lower index is served first; others remain pending.
  - cr_rd changing during SERVICE has no effect until IDLE.

Test Plan:
- Reset low mid-SERVICE → bank = 0, busy = 0, pending = 8'h00 immediately, without waiting for clk; after release, no sr1_wr pulse.
- cr_rd = 16'h0401, irq[2] rise, then instr_done → one-cycle ENTER with sr1_wr = 16'h000A, take = 1, bank = 1; pending[2] = 0; bank stays 1 until reti, then 0 two cycles after reti.
- cr_rd = 16'h0000, irq[5] rise, instr_done → no take; pending = 8'h20. Then cr_rd = 16'h2001, instr_done → sr1_wr = 16'h000D.
- trap and irq[0] eligible on the same instr_done (cr_rd = 16'h0101) → first ENTER has sr1_wr = 16'h0010. After reti plus the next instr_done, second ENTER has sr1_wr = 16'h0008.
- irq[3] held high for 50 cycles → exactly one pending set. A second rising edge during SERVICE → pending[3] = 1, serviced after reti.
- irq[1] re-edge aligned with the clearing posedge in ENTER → pending[1] remains 1; a second service follows.

Source files
------------

// File: rtl/irq_bank_ctrl.sv
// Interrupt/trap sequencer ahead of the banked register file: synchronises irq lines,
// prioritises them against the control register and enters the supervisor bank.
//   state   | meaning
//   IDLE    | user bank, waiting for instr_done with an eligible source
//   ENTER   | one cycle: supervisor bank, take pulse, cause written to SR1
//   SERVICE | handler running in supervisor bank, waits for reti
//   EXIT    | one cycle still in supervisor bank, then back to user
module irq_bank_ctrl #(
    parameter int          NIRQ       = 8,
    parameter logic [15:0] CAUSE_BASE = 16'h0008,
    parameter logic [15:0] TRAP_CAUSE = 16'h0010
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq,
    input  logic            trap,
    input  logic [15:0]     cr_rd,
    input  logic            instr_done,
    input  logic            reti,
    output logic            bank,
    output logic [15:0]     sr1_wr,
    output logic            take,
    output logic [NIRQ-1:0] pending,
    output logic            busy
);
    localparam int IW = $clog2(NIRQ);

    typedef enum logic [1:0] {IDLE, ENTER, SERVICE, EXIT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [NIRQ-1:0] s1, s2, s3;
    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] pend_q;
    logic [NIRQ-1:0] eligible;
    logic [NIRQ-1:0] clr_pend;
    logic            trap_pend;
    logic            clr_trap;
    logic            win_trap;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   sel_idx;
    logic [15:0]     sel_cause;
    logic            unused_cr;

    assign rise      = s2 & ~s3;
    assign eligible  = pend_q & cr_rd[15:8] & {NIRQ{cr_rd[0]}};
    assign unused_cr = ^cr_rd[7:1];
    assign pending   = pend_q;
    assign busy      = (state != IDLE);

    // Descending scan so the lowest eligible index is the one left standing.
    always_comb begin
        sel_idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (eligible[i]) sel_idx = IW'(i);
        end
    end

    assign sel_cause = trap_pend ? TRAP_CAUSE : (CAUSE_BASE | 16'(sel_idx));

    always_comb begin
        state_nxt = state;
        clr_pend  = '0;
        clr_trap  = 1'b0;
        case (state)
            IDLE: begin
                if (instr_done && (trap_pend || (|eligible))) state_nxt = ENTER;
            end
            ENTER: begin
                state_nxt = SERVICE;
                if (win_trap) clr_trap = 1'b1;
                else          clr_pend[win_idx] = 1'b1;
            end
            SERVICE: begin
                if (reti) state_nxt = EXIT;
            end
            EXIT: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Clears are applied before new requests are OR-ed in, so a coincident set wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            pend_q    <= '0;
            trap_pend <= 1'b0;
            win_trap  <= 1'b0;
            win_idx   <= '0;
            bank      <= 1'b0;
            take      <= 1'b0;
            sr1_wr    <= 16'h0000;
        end else begin
            state     <= state_nxt;
            s1        <= irq;
            s2        <= s1;
            s3        <= s2;
            pend_q    <= (pend_q & ~clr_pend) | rise;
            trap_pend <= (trap_pend & ~clr_trap) | trap;
            if (state == IDLE && state_nxt == ENTER) begin
                win_trap <= trap_pend;
                win_idx  <= sel_idx;
            end
            bank   <= (state_nxt != IDLE);
            take   <= (state_nxt == ENTER);
            sr1_wr <= (state_nxt == ENTER) ? sel_cause : 16'h0000;
        end
    end
endmodule
